// File: rtl/gsim_host_ctrl.sv
// gsim_host_ctrl: host-side loader/unloader for the Gauss-Seidel solver.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   s_valid/s_ready/s_data              upstream b-word stream (ready only in LOAD)
//   sol_in_en/sol_b                     registered burst of N b words to the solver
//   sol_out_valid/sol_x                 solver result burst (x lags valid by XLAT)
//   m_valid/m_ready/m_data/m_last       downstream result stream, last on word N-1
//   busy                                high in every state except LOAD
//   err                                 sticky WAIT watchdog error
// Optional feature macro: GSIM_HOST_TIMEOUT_EN (WAIT watchdog; err tied 0 when undefined).
module gsim_host_ctrl #(
  parameter int N       = 16,
  parameter int BW      = 16,
  parameter int XW      = 32,
  parameter int XLAT    = 1,
  parameter int TIMEOUT = 8192
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [BW-1:0] s_data,
  output logic          sol_in_en,
  output logic [BW-1:0] sol_b,
  input  logic          sol_out_valid,
  input  logic [XW-1:0] sol_x,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [XW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          err
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [2:0] {S_LOAD, S_SEND, S_WAIT, S_CAPT, S_DRAIN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic sol_in_en_q, sol_in_en_d;
  logic [BW-1:0] sol_b_q, sol_b_d;
  logic [XLAT-1:0] pipe_q, pipe_d;
  logic [BW-1:0] bbuf [N];
  logic [XW-1:0] xbuf [N];
  logic last, s_fire, m_fire, cap_en;
`ifdef GSIM_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign last      = idx_q == IW'(N - 1);
  assign s_ready   = state_q == S_LOAD;
  assign s_fire    = s_valid && s_ready;
  assign m_valid   = state_q == S_DRAIN;
  assign m_fire    = m_valid && m_ready;
  assign m_data    = xbuf[idx_q];
  assign m_last    = m_valid && last;
  assign busy      = state_q != S_LOAD;
  assign sol_in_en = sol_in_en_q;
  assign sol_b     = sol_b_q;
  // x arrives XLAT cycles after its valid; only valids seen in WAIT/CAPTURE enter the pipe,
  // so stray pulses during LOAD/SEND can never produce a capture.
  assign cap_en    = pipe_q[XLAT-1] && state_q == S_CAPT;
  always_comb begin
    pipe_d[0] = sol_out_valid && (state_q == S_WAIT || state_q == S_CAPT);
    for (int i = 1; i < XLAT; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sol_in_en_d = 1'b0;
    sol_b_d     = sol_b_q;
`ifdef GSIM_HOST_TIMEOUT_EN
    tcnt_d      = state_q == S_WAIT ? tcnt_q + 1'b1 : '0;
    err_d       = err_q;
`endif
    case (state_q)
      S_LOAD: if (s_fire) begin
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? S_SEND : S_LOAD;
      end
      S_SEND: begin
        sol_in_en_d = 1'b1;
        sol_b_d     = bbuf[idx_q];
        idx_d       = last ? '0 : idx_q + 1'b1;
        state_d     = last ? S_WAIT : S_SEND;
      end
      S_WAIT: if (sol_out_valid) state_d = S_CAPT;
`ifdef GSIM_HOST_TIMEOUT_EN
      else if (tcnt_q == TW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = S_LOAD;
      end
`endif
      S_CAPT: if (cap_en) begin
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? S_DRAIN : S_CAPT;
      end
      S_DRAIN: if (m_fire) begin
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? S_LOAD : S_DRAIN;
      end
      default: state_d = S_LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      sol_in_en_q <= 1'b0;
      sol_b_q     <= '0;
      pipe_q      <= '0;
`ifdef GSIM_HOST_TIMEOUT_EN
      tcnt_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sol_in_en_q <= sol_in_en_d;
      sol_b_q     <= sol_b_d;
      pipe_q      <= pipe_d;
`ifdef GSIM_HOST_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      err_q       <= err_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (s_fire) bbuf[idx_q] <= s_data;
    if (cap_en) xbuf[idx_q] <= sol_x;
  end
endmodule
